// File: rtl/memory_io_seq_if.sv
// Bus bundle for memory_io_seq: control/input/output bridge slaves plus the engine stream.
// slave = sequencer side, master = HPS bridges and engine side.
interface memory_io_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        ctl_address;
  logic              ctl_read;
  logic              ctl_write;
  logic [DATA_W-1:0] ctl_writedata;
  logic [DATA_W-1:0] ctl_readdata;

  logic              in_write;
  logic [7:0]        in_address;
  logic [DATA_W-1:0] in_writedata;

  logic              out_read;
  logic [7:0]        out_address;
  logic [DATA_W-1:0] out_readdata;

  logic              eng_clear;
  logic              eng_in_valid;
  logic [DATA_W-1:0] eng_in_data;
  logic              eng_in_ready;
  logic              eng_out_valid;
  logic [DATA_W-1:0] eng_out_data;

  modport slave (
    input  ctl_address, ctl_read, ctl_write, ctl_writedata,
    output ctl_readdata,
    input  in_write, in_address, in_writedata,
    input  out_read, out_address,
    output out_readdata,
    output eng_clear, eng_in_valid, eng_in_data,
    input  eng_in_ready, eng_out_valid, eng_out_data
  );

  modport master (
    output ctl_address, ctl_read, ctl_write, ctl_writedata,
    input  ctl_readdata,
    output in_write, in_address, in_writedata,
    output out_read, out_address,
    input  out_readdata,
    input  eng_clear, eng_in_valid, eng_in_data,
    output eng_in_ready, eng_out_valid, eng_out_data
  );
endinterface

// File: rtl/memory_io_seq.sv
// Job sequencer: streams LENGTH operands from inbuf to the engine and collects results in outbuf.
// Optional CYCLES busy-cycle counter is built when MEMIO_SEQ_CYCLE_COUNT_EN is defined.
module memory_io_seq #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32
) (
  input logic            clk_clk,
  input logic            reset_reset,
  memory_io_seq_if.slave bus
);
  localparam logic [8:0] DepthLen = 9'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e            state_q, state_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        fetch_q, fetch_d;
  logic [8:0]        issue_q, issue_d;
  logic [8:0]        res_q, res_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic              aborted_q, aborted_d;
  logic              clear_q, clear_d;
  logic [DATA_W-1:0] ctl_rdata_q, ctl_rdata_d;
  logic [DATA_W-1:0] out_rdata_q;
  logic [31:0]       cycles_rd;

  logic [DATA_W-1:0] inbuf  [DEPTH];
  logic [DATA_W-1:0] outbuf [DEPTH];

  logic       busy, ctrl_wr, start_req, abort_req, xfer, res_take, in_we;
  logic [8:0] issue_nxt, res_nxt;

  assign busy      = (state_q != StIdle);
  assign ctrl_wr   = bus.ctl_write && (bus.ctl_address == 8'h00);
  // ABORT in the same word as START suppresses the START.
  assign start_req = ctrl_wr && bus.ctl_writedata[0] && !bus.ctl_writedata[1];
  assign abort_req = ctrl_wr && bus.ctl_writedata[1];
  assign xfer      = (state_q == StFeed) && hold_valid_q && bus.eng_in_ready;
  assign res_take  = busy && !abort_req && bus.eng_out_valid && (res_q < len_q);
  assign issue_nxt = issue_q + {8'd0, xfer};
  assign res_nxt   = res_q + {8'd0, res_take};
  assign in_we     = bus.in_write && !busy;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    fetch_d      = fetch_q;
    issue_d      = issue_nxt;
    res_d        = res_nxt;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    done_d       = done_q;
    wr_err_d     = wr_err_q | (bus.in_write & busy);
    aborted_d    = aborted_q;
    clear_d      = 1'b0;

    if (bus.ctl_write && (bus.ctl_address == 8'h02)) begin
      len_d = (bus.ctl_writedata > DATA_W'(DEPTH)) ? DepthLen : bus.ctl_writedata[8:0];
    end

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          clear_d   = 1'b1;
          done_d    = (len_q == '0);
          wr_err_d  = 1'b0;
          aborted_d = 1'b0;
          fetch_d   = '0;
          issue_d   = '0;
          res_d     = '0;
          if (len_q != '0) state_d = StFeed;
        end
      end
      StFeed: begin
        if (abort_req) begin
          state_d      = StIdle;
          clear_d      = 1'b1;
          aborted_d    = 1'b1;
          hold_valid_d = 1'b0;
        end else begin
          // Holding register refills on the transfer edge so issue can run at one per cycle.
          if (xfer || !hold_valid_q) begin
            if (fetch_q < len_q) begin
              hold_valid_d = 1'b1;
              hold_data_d  = inbuf[fetch_q[7:0]];
              fetch_d      = fetch_q + 9'd1;
            end else begin
              hold_valid_d = 1'b0;
            end
          end
          if (issue_nxt >= len_q) begin
            if (res_nxt >= len_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (abort_req) begin
          state_d      = StIdle;
          clear_d      = 1'b1;
          aborted_d    = 1'b1;
          hold_valid_d = 1'b0;
        end else if (res_nxt >= len_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      fetch_q      <= '0;
      issue_q      <= '0;
      res_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
      aborted_q    <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      fetch_q      <= fetch_d;
      issue_q      <= issue_d;
      res_q        <= res_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      done_q       <= done_d;
      wr_err_q     <= wr_err_d;
      aborted_q    <= aborted_d;
      clear_q      <= clear_d;
    end
  end

  // Buffers carry no reset; their contents are undefined until written.
  always_ff @(posedge clk_clk) begin
    if (in_we)    inbuf[bus.in_address] <= bus.in_writedata;
    if (res_take) outbuf[res_q[7:0]]    <= bus.eng_out_data;
  end

`ifdef MEMIO_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cycles_q <= '0;
    end else if (!busy && start_req) begin
      cycles_q <= '0;
    end else if (busy && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  always_comb begin
    ctl_rdata_d = '0;
    case (bus.ctl_address)
      8'h01:   ctl_rdata_d = DATA_W'({aborted_q, wr_err_q, done_q, busy});
      8'h02:   ctl_rdata_d = DATA_W'(len_q);
      8'h03:   ctl_rdata_d = DATA_W'(res_q);
      8'h04:   ctl_rdata_d = DATA_W'(cycles_rd);
      default: ctl_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctl_rdata_q <= '0;
      out_rdata_q <= '0;
    end else begin
      ctl_rdata_q <= bus.ctl_read ? ctl_rdata_d : '0;
      if (bus.out_read) out_rdata_q <= outbuf[bus.out_address];
    end
  end

  assign bus.ctl_readdata = ctl_rdata_q;
  assign bus.out_readdata = out_rdata_q;
  assign bus.eng_clear    = clear_q;
  assign bus.eng_in_valid = hold_valid_q;
  assign bus.eng_in_data  = hold_data_q;
endmodule

// File: tb/tb_memory_io_seq.sv
// Directed bench for memory_io_seq: engine model (+1, configurable latency/ready) and
// an operand-order scoreboard checked every cycle, plus register/buffer readback checks.
module tb_memory_io_seq;
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  always #5 clk_clk = ~clk_clk;

  memory_io_seq_if bus ();

  memory_io_seq dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .bus         (bus)
  );

  int total = 0;
  int bad = 0;

  // Model of the input buffer as the bench has legally written it.
  logic [31:0] exp_in [256];

  // Engine model knobs (written by the main process only).
  int lat = 1;
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 ready until ready_lim transfers
  int ready_lim = 0;
  int xfer_base = 0;

  // Counters stepped by the compare process only.
  int cyc = 0;
  int xfer_cnt = 0;
  int clr_cnt = 0;
  int valid_cnt = 0;
  logic [31:0] pend_data [$];
  int pend_due [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Compare process and engine model: everything sampled/driven on the falling edge.
  always @(negedge clk_clk) begin
    if (reset_reset) begin
      pend_data.delete();
      pend_due.delete();
      bus.eng_in_ready  = 1'b0;
      bus.eng_out_valid = 1'b0;
      bus.eng_out_data  = '0;
    end else begin
      cyc++;
      if (bus.eng_clear) clr_cnt++;
      if (bus.eng_in_valid) valid_cnt++;
      if (bus.eng_in_valid && bus.eng_in_ready) begin
        check("operand", bus.eng_in_data, exp_in[(xfer_cnt - xfer_base) % 256]);
        pend_data.push_back(bus.eng_in_data + 32'd1);
        pend_due.push_back(cyc + lat);
        xfer_cnt++;
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data  = pend_data.pop_front();
        void'(pend_due.pop_front());
      end else begin
        bus.eng_out_valid = 1'b0;
        bus.eng_out_data  = '0;
      end
      case (ready_mode)
        1:       bus.eng_in_ready = ~bus.eng_in_ready;
        2:       bus.eng_in_ready = ((xfer_cnt - xfer_base) < ready_lim);
        default: bus.eng_in_ready = 1'b1;
      endcase
    end
  end

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic ctl_wr(input logic [7:0] a, input logic [31:0] d);
    bus.ctl_address = a;
    bus.ctl_writedata = d;
    bus.ctl_write = 1'b1;
    step();
    bus.ctl_write = 1'b0;
  endtask

  task automatic ctl_rd(input logic [7:0] a, output logic [31:0] d);
    bus.ctl_address = a;
    bus.ctl_read = 1'b1;
    step();
    bus.ctl_read = 1'b0;
    d = bus.ctl_readdata;
  endtask

  task automatic in_wr(input logic [7:0] a, input logic [31:0] d);
    bus.in_address = a;
    bus.in_writedata = d;
    bus.in_write = 1'b1;
    step();
    bus.in_write = 1'b0;
  endtask

  task automatic out_rd(input logic [7:0] a, output logic [31:0] d);
    bus.out_address = a;
    bus.out_read = 1'b1;
    step();
    bus.out_read = 1'b0;
    d = bus.out_readdata;
  endtask

  task automatic load(input int n, input logic [31:0] base, input logic [31:0] stride);
    for (int i = 0; i < n; i++) begin
      exp_in[i] = base + stride * i;
      in_wr(8'(i), exp_in[i]);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [31:0] s;
    int n;
    n = 0;
    ctl_rd(8'h01, s);
    while (s[0] && n < budget) begin
      ctl_rd(8'h01, s);
      n++;
    end
    total++;
    if (s[0]) begin
      bad++;
      $display("FAIL %s: busy still 1 after %0d polls, want 0", name, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, c1, c2;
    logic seen;
    int b_clr, b_valid;

    bus.ctl_address = '0; bus.ctl_read = 1'b0; bus.ctl_write = 1'b0; bus.ctl_writedata = '0;
    bus.in_write = 1'b0; bus.in_address = '0; bus.in_writedata = '0;
    bus.out_read = 1'b0; bus.out_address = '0;

    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_ctl_readdata", bus.ctl_readdata, 32'h0);
    check("rst_out_readdata", bus.out_readdata, 32'h0);
    check("rst_eng_clear", {31'd0, bus.eng_clear}, 32'h0);
    check("rst_eng_in_valid", {31'd0, bus.eng_in_valid}, 32'h0);
    check("rst_eng_in_data", bus.eng_in_data, 32'h0);
    reset_reset = 1'b0;
    step();
    ctl_rd(8'h01, d); check("rst_status", d, 32'h0);
    ctl_rd(8'h02, d); check("rst_length", d, 32'h0);

    // Basic job: +1 engine, 3-cycle latency, always ready.
    lat = 3; ready_mode = 0;
    load(4, 32'd1, 32'd1);
    ctl_wr(8'h02, 32'd4);
    xfer_base = xfer_cnt; b_clr = clr_cnt;
    ctl_wr(8'h00, 32'h1);
    check("clear_at_n1", {31'd0, bus.eng_clear}, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seen |= bus.eng_in_valid;
      if (k < 2) step();
    end
    check("valid_by_n3", {31'd0, seen}, 32'h1);
    wait_idle("job4_idle", 200);
    ctl_rd(8'h01, d); check("job4_status", d, 32'h2);
    ctl_rd(8'h03, d); check("job4_rescnt", d, 32'd4);
    out_rd(8'd0, d); check("job4_out0", d, 32'd2);
    out_rd(8'd1, d); check("job4_out1", d, 32'd3);
    out_rd(8'd2, d); check("job4_out2", d, 32'd4);
    out_rd(8'd3, d); check("job4_out3", d, 32'd5);
    check("job4_xfers", 32'(xfer_cnt - xfer_base), 32'd4);
    check("job4_clears", 32'(clr_cnt - b_clr), 32'd1);
    ctl_rd(8'h00, d); check("ctrl_reads_0", d, 32'h0);
    ctl_rd(8'h07, d); check("unmapped_reads_0", d, 32'h0);

    // Clamped full-depth job with ready toggling.
    ctl_wr(8'h02, 32'd300);
    ctl_rd(8'h02, d); check("length_clamp", d, 32'd256);
    load(256, 32'hA000_0000, 32'd7);
    lat = 1; ready_mode = 1;
    xfer_base = xfer_cnt;
    ctl_wr(8'h00, 32'h1);
    wait_idle("job256_idle", 1500);
    ctl_rd(8'h01, d); check("job256_status", d, 32'h2);
    check("job256_xfers", 32'(xfer_cnt - xfer_base), 32'd256);
    ctl_rd(8'h03, d); check("job256_rescnt", d, 32'd256);
    out_rd(8'd0, d); check("job256_out0", d, 32'hA000_0001);
    out_rd(8'd128, d); check("job256_out128", d, exp_in[128] + 32'd1);
    out_rd(8'd255, d); check("job256_out255", d, 32'hA000_06FA);

    // Zero-length job.
    ready_mode = 0;
    ctl_wr(8'h02, 32'd0);
    b_clr = clr_cnt; b_valid = valid_cnt;
    ctl_wr(8'h00, 32'h1);
    ctl_rd(8'h01, d); check("len0_status", d, 32'h2);
    repeat (4) step();
    check("len0_no_valid", 32'(valid_cnt - b_valid), 32'd0);
    check("len0_clears", 32'(clr_cnt - b_clr), 32'd1);

    // Writes and START while busy.
    load(16, 32'h0000_5000, 32'd3);
    ctl_wr(8'h02, 32'd16);
    xfer_base = xfer_cnt; b_clr = clr_cnt;
    ctl_wr(8'h00, 32'h1);
    ctl_rd(8'h01, d); check("busy_at_n1", d & 32'h1, 32'h1);
    bus.in_address = 8'd5; bus.in_writedata = 32'hDEAD_BEEF; bus.in_write = 1'b1;
    step();
    bus.in_write = 1'b0;
    ctl_wr(8'h00, 32'h1);
    wait_idle("job16_idle", 200);
    ctl_rd(8'h01, d); check("job16_status", d, 32'h6);
    check("job16_xfers", 32'(xfer_cnt - xfer_base), 32'd16);
    check("job16_clears", 32'(clr_cnt - b_clr), 32'd1);
    out_rd(8'd5, d); check("job16_out5", d, 32'h0000_5010);

    // Abort after six transfers; results from the engine arrive after the abort.
    lat = 12; ready_mode = 2; ready_lim = 6;
    xfer_base = xfer_cnt; b_clr = clr_cnt;
    ctl_wr(8'h00, 32'h1);
    for (int k = 0; k < 50 && (xfer_cnt - xfer_base) < 6; k++) step();
    check("abort_pre_xfers", 32'(xfer_cnt - xfer_base), 32'd6);
    ctl_wr(8'h00, 32'h2);
    check("abort_clear", {31'd0, bus.eng_clear}, 32'h1);
    ctl_rd(8'h01, d); check("abort_status", d, 32'h8);
    ctl_rd(8'h03, d); check("abort_rescnt", d, 32'd0);
    repeat (20) step();
    ctl_rd(8'h03, d); check("late_rescnt", d, 32'd0);
    check("abort_clears", 32'(clr_cnt - b_clr), 32'd2);
    ready_mode = 0; lat = 1;
    ctl_wr(8'h02, 32'd0);
    ctl_wr(8'h00, 32'h1);
    ctl_rd(8'h01, d); check("restart_clears_aborted", d, 32'h2);

    // START+ABORT in one word while idle does nothing.
    ctl_wr(8'h02, 32'd4);
    b_clr = clr_cnt;
    ctl_wr(8'h00, 32'h3);
    step();
    ctl_rd(8'h01, d); check("start_abort_idle", d, 32'h2);
    check("start_abort_clears", 32'(clr_cnt - b_clr), 32'd0);

    // Busy-cycle counter.
    ctl_wr(8'h02, 32'd8);
    xfer_base = xfer_cnt;
    ctl_wr(8'h00, 32'h1);
    wait_idle("job8_idle", 200);
    ctl_rd(8'h04, c1);
`ifdef MEMIO_SEQ_CYCLE_COUNT_EN
    total++;
    if (c1 < 32'd9 || c1 > 32'd64) begin
      bad++;
      $display("FAIL cycles_range: got %0d want 9..64", c1);
    end
    repeat (5) step();
    ctl_rd(8'h04, c2); check("cycles_stable", c2, c1);
    ctl_wr(8'h00, 32'h1);
    ctl_rd(8'h04, d); check("cycles_cleared", d, 32'h0);
    wait_idle("job8b_idle", 200);
`else
    check("cycles_disabled", c1, 32'h0);
    c2 = c1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_io_seq.md
# memory_io_seq

Fabric-side job sequencer behind the HPS bridge ports of the memory I/O system. Serves the control, input-write and output-read bridges as Avalon slaves: the HPS loads operands into an internal input buffer, programs a length and starts a job, and reads results back from an internal output buffer. A job streams `LENGTH` operands through an attached numerical engine over a valid/ready handshake and collects its results. Completion and errors are reported in status registers.

## Interface
- `DEPTH`, 256: words per buffer; equals the 2^8 bridge address space.
- `DATA_W`, 32: word width.

Ports:
- `clk_clk`  in  1  single clock; all logic on the rising edge.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `ctl_address`  in  8  control register address (word).
- `ctl_read`  in  1  register read strobe.
- `ctl_write`  in  1  register write strobe.
- `ctl_writedata`  in  32  register write data.
- `ctl_readdata`  out  32  register read data, 1-cycle latency.
- `in_write`  in  1  input buffer write strobe.
- `in_address`  in  8  input buffer index.
- `in_writedata`  in  32  operand word.
- `out_read`  in  1  output buffer read strobe.
- `out_address`  in  8  output buffer index.
- `out_readdata`  out  32  result word, 1-cycle latency.
- `eng_clear`  out  1  1-cycle pulse; resets engine pipeline.
- `eng_in_valid`  out  1  operand valid.
- `eng_in_data`  out  32  operand.
- `eng_in_ready`  in  1  engine accepts operand.
- `eng_out_valid`  in  1  result valid; no backpressure.
- `eng_out_data`  in  32  result.

## Operation
- Registers:
  - 0x00 CTRL (W): bit0 START, bit1 ABORT, self-clearing; reads 0.
  - 0x01 STATUS (R): bit0 busy, bit1 done, bit2 wr_err, bit3 aborted.
  - 0x02 LENGTH (R/W): 9 bits, reset 0; writes >DEPTH clamp to DEPTH.
  - 0x03 RESCNT (R): results written in the current/last job.
  - 0x04 CYCLES (R): see Configuration.
  - Other addresses read 0; writes to them are ignored.
- FSM states: IDLE, FEED, DRAIN.
- IDLE:
  - START → pulse `eng_clear`, clear done/wr_err/aborted, zero the issue and result counters, go to FEED.
  - If LENGTH=0, START sets done the next cycle and stays in IDLE; `eng_clear` still pulses.
- FEED:
  - Input buffer is read through a 1-entry holding register that drives `eng_in_data`; `eng_in_valid` is high while the register is full.
  - An operand transfers when `eng_in_valid && eng_in_ready`.
  - The holding register refills on the same transfer edge as long as the issue count is below LENGTH.
  - After the LENGTH-th transfer → DRAIN.
- Results (FEED or DRAIN): each `eng_out_valid` writes `eng_out_data` to `outbuf[rescnt]` and increments rescnt.
- DRAIN: when rescnt reaches LENGTH → set done, go to IDLE. Results arriving in IDLE are discarded.
- ABORT while busy:
  - Go to IDLE, pulse `eng_clear`, set aborted, leave done clear.
  - The holding register empties.
  - The partial output buffer contents are retained.
  - ABORT in IDLE has no effect.
- START while busy is ignored. If START and ABORT are written in the same word, ABORT wins.
- `in_write` while busy: write is dropped and wr_err is set.
- `in_write` in IDLE writes `inbuf[in_address]`.
- `out_read` is legal at any time and returns the current contents.
- Reset: the FSM enters IDLE and all registers clear. Buffer contents are undefined after reset.

## Timing
- Reset values:
  - `ctl_readdata`, `out_readdata`: 0.
  - `eng_clear`, `eng_in_valid`: 0.
  - `eng_in_data`: 0.
  - busy=0.
- `ctl_readdata` is valid the cycle after `ctl_read`.
- `out_readdata` is valid the cycle after `out_read`.
- START on cycle N:
  - `eng_clear` is high in N+1.
  - busy reads 1 from N+1.
  - `eng_in_valid` rises no later than N+3.
- With `eng_in_ready` held high, the sustained issue rate is 1 operand per cycle.
- done rises 1 cycle after the LENGTH-th `eng_out_valid`.
- A result captured on cycle N can be read back from cycle N+1.
- Counter arithmetic is 9-bit unsigned. Buffer indices use the low 8 bits; index DEPTH-1 is the last entry, with no wrap within a job.

## Configuration
- `MEMIO_SEQ_CYCLE_COUNT_EN` defined:
  - CYCLES is a 32-bit counter, cleared on START.
  - It increments every cycle while busy, saturates at 0xFFFFFFFF, and holds its value after done/abort.
- Undefined: CYCLES reads 0 and no counter logic is generated.

## Test plan
- Load inbuf[0..3] = 1,2,3,4; LENGTH=4; START; engine model = +1 with 3-cycle latency, always ready → done=1, RESCNT=4, outbuf reads 2,3,4,5.
- LENGTH=300 → LENGTH reads 256. Run with `eng_in_ready` toggling 1010… → exactly 256 operand transfers in index order, done=1, busy=0.
- LENGTH=0, START → done=1 within 2 cycles, no `eng_in_valid`, one `eng_clear` pulse.
- During a LENGTH=16 job: `in_write` addr 5 → inbuf[5] unchanged, wr_err=1. A second START has no effect.
- ABORT after 6 transfers → busy=0, aborted=1, done=0, `eng_clear` pulse. Late `eng_out_valid` leaves RESCNT unchanged. A new START clears aborted.
- With the macro defined and a LENGTH=8 job with an always-ready 1-cycle engine → CYCLES is nonzero, stable after done, and 0 right after the next START. Without the macro → CYCLES reads 0.
